psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/cnn_pkg.sv | 16 +
 rtl/skew_delay.sv | 33 +++
 rtl/psum_drain.sv | 126 ++++++++++++
 tb/tb_psum_drain.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and a constant-time clog2 helper used for sizing.
package cnn_pkg;

  localparam int CNN_DATA_SIZE = 16;
  localparam int CNN_COLS      = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Reset-cleared shift register of STAGES registers; STAGES=0 degenerates to a wire.
module skew_delay #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_reg [STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < STAGES; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/psum_drain.sv
// Deskews systolic-array bottom-row partial sums into aligned rows and buffers them in a FIFO.
// Optional macro PSUM_DRAIN_RELU_EN clamps negative columns to zero at FIFO write.
module psum_drain
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE = CNN_DATA_SIZE,
  parameter int COLS      = CNN_COLS,
  parameter int DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [COLS*DATA_SIZE-1:0] in_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*DATA_SIZE-1:0] out_data,
  output logic [clog2(DEPTH):0]     level,
  output logic                      overflow
);

  localparam int AW    = clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int ROW_W = COLS * DATA_SIZE;
  localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

  logic [ROW_W-1:0] aligned_row;
  logic [ROW_W-1:0] wr_row;
  logic             aligned_valid;

  // Column j arrives j cycles late, so it is held COLS-1-j cycles to line up with column COLS-1.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      skew_delay #(
        .WIDTH  (DATA_SIZE),
        .STAGES (COLS - 1 - gi)
      ) u_col_delay (
        .clk   (clk),
        .reset (reset),
        .din   (in_c[gi*DATA_SIZE +: DATA_SIZE]),
        .dout  (aligned_row[gi*DATA_SIZE +: DATA_SIZE])
      );
`ifdef PSUM_DRAIN_RELU_EN
      assign wr_row[gi*DATA_SIZE +: DATA_SIZE] =
        aligned_row[gi*DATA_SIZE + DATA_SIZE - 1] ? '0 : aligned_row[gi*DATA_SIZE +: DATA_SIZE];
`else
      assign wr_row[gi*DATA_SIZE +: DATA_SIZE] = aligned_row[gi*DATA_SIZE +: DATA_SIZE];
`endif
    end
  endgenerate

  skew_delay #(
    .WIDTH  (1),
    .STAGES (COLS - 1)
  ) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .din   (in_valid),
    .dout  (aligned_valid)
  );

  logic [ROW_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      level_reg, level_next;
  logic             overflow_reg, overflow_next;
  logic [ROW_W-1:0] head_reg;
  logic             full;
  logic             pop;
  logic             do_write;
  logic             head_bypass;

  always_comb begin
    full          = (level_reg == FULL_LEVEL);
    pop           = out_valid && out_ready;
    // A full FIFO still accepts the row when the head leaves in the same cycle.
    do_write      = aligned_valid && (!full || pop);
    wr_ptr_next   = do_write ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next   = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    overflow_next = overflow_reg || (aligned_valid && full && !pop);
    level_next    = level_reg;
    if (do_write && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (!do_write && pop) begin
      level_next = level_reg - 1'b1;
    end
    head_bypass   = do_write && (wr_ptr_reg == rd_ptr_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg] <= wr_row;
  end

  // Registered read of the next head; a row landing in the head slot this cycle is forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg <= '0;
    end else if (level_next == '0) begin
      head_reg <= '0;
    end else if (head_bypass) begin
      head_reg <= wr_row;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  assign out_valid = (level_reg != '0);
  assign out_data  = head_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: table-driven single row, directed corner sequences, random traffic vs a queue model.
module tb_psum_drain;

  localparam int DS    = 16;
  localparam int COLS  = 4;
  localparam int DEPTH = 8;
  localparam int W     = DS * COLS;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_c;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [LW-1:0] level;
  logic          overflow;

  always #5 clk = ~clk;

  psum_drain #(
    .DATA_SIZE (DS),
    .COLS      (COLS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: rows launched in the last COLS cycles, FIFO as a bounded queue.
  logic         hv [COLS];
  logic [W-1:0] hr [COLS];
  logic [W-1:0] mq [$];
  logic         m_ovf;
  logic [W-1:0] dut_pops [$];
  int           max_level;

  typedef struct {
    logic         v;
    logic [W-1:0] c;
    logic         rdy;
    logic         ev;
    logic [W-1:0] ed;
    int           el;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] r);
    logic [W-1:0] o;
    o = r;
`ifdef PSUM_DRAIN_RELU_EN
    for (int j = 0; j < COLS; j++) if (r[j*DS + DS - 1]) o[j*DS +: DS] = '0;
`endif
    return o;
  endfunction

  function automatic logic [W-1:0] mk_row(input int n);
    logic [W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*DS +: DS] = DS'((n * 16 + j + 1) * ((j % 2 == 1) ? -1 : 1));
    return r;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_c = '0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    for (int k = 0; k < COLS; k++) begin hv[k] = 1'b0; hr[k] = '0; end
    mq.delete();
    dut_pops.delete();
    m_ovf = 1'b0;
    max_level = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic step(input logic v, input logic [W-1:0] row, input logic rdy);
    logic push_ok;
    logic do_pop;
    for (int k = COLS - 1; k > 0; k--) begin hv[k] = hv[k-1]; hr[k] = hr[k-1]; end
    hv[0] = v;
    hr[0] = row;
    for (int j = 0; j < COLS; j++) in_c[j*DS +: DS] = hv[j] ? hr[j][j*DS +: DS] : DS'($urandom);
    in_valid = v;
    out_ready = rdy;
    if (out_valid && rdy) dut_pops.push_back(out_data);
    @(posedge clk);
    do_pop = (mq.size() > 0) && rdy;
    push_ok = 1'b0;
    if (hv[COLS-1]) begin
      if (mq.size() < DEPTH || do_pop) push_ok = 1'b1;
      else m_ovf = 1'b1;
    end
    if (do_pop) void'(mq.pop_front());
    if (push_ok) mq.push_back(relu(hr[COLS-1]));
    #1;
    check("valid", out_valid, mq.size() > 0);
    check("level", level, mq.size());
    check("ovf", overflow, m_ovf);
    if (mq.size() > 0) check("data", out_data, mq[0]);
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_c = '0;
    out_ready = 1'b0;
    apply_reset();

    // Single row 1,-2,3,-4 on skewed columns; unrelated slices carry junk.
    tbl[0] = '{1'b1, {16'h7777, 16'h5555, 16'h3333, 16'h0001}, 1'b1, 1'b0, '0, 0};
    tbl[1] = '{1'b0, {16'h7777, 16'h5555, 16'hFFFE, 16'h1111}, 1'b1, 1'b0, '0, 0};
    tbl[2] = '{1'b0, {16'h7777, 16'h0003, 16'h4444, 16'h1111}, 1'b1, 1'b0, '0, 0};
    tbl[3] = '{1'b0, {16'hFFFC, 16'h6666, 16'h4444, 16'h1111}, 1'b1, 1'b1,
               {16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001}, 1};
    tbl[4] = '{1'b0, {16'h8888, 16'h6666, 16'h4444, 16'h2222}, 1'b1, 1'b0, '0, 0};
    tbl[5] = '{1'b0, {16'h8888, 16'h6666, 16'h4444, 16'h2222}, 1'b1, 1'b0, '0, 0};
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v;
      in_c = tbl[i].c;
      out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      $display("table cycle %0d: valid=%0b level=%0d data=%h", i + 1, out_valid, level, out_data);
      check("tbl_valid", out_valid, tbl[i].ev);
      check("tbl_level", level, tbl[i].el);
      if (tbl[i].ev) check("tbl_data", out_data, relu(tbl[i].ed));
    end

    // Streaming 10 back-to-back rows.
    apply_reset();
    for (int i = 0; i < 10; i++) step(1'b1, mk_row(i), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    check("stream_count", dut_pops.size(), 10);
    for (int i = 0; i < 10 && i < dut_pops.size(); i++) check("stream_row", dut_pops[i], relu(mk_row(i)));
    check("stream_maxlvl", max_level <= 1, 1);
    check("stream_ovf", overflow, 0);
    $display("streaming: %0d rows popped, max level %0d", dut_pops.size(), max_level);

    // Backpressure: 9 rows into a depth-8 FIFO.
    apply_reset();
    for (int i = 0; i < 9; i++) step(1'b1, mk_row(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check("bp_level", level, 8);
    check("bp_ovf", overflow, 1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    check("bp_count", dut_pops.size(), 8);
    for (int i = 0; i < 8 && i < dut_pops.size(); i++) check("bp_row", dut_pops[i], relu(mk_row(i)));
    check("bp_ovf_sticky", overflow, 1);
    $display("backpressure: %0d rows drained, overflow=%0b", dut_pops.size(), overflow);

    // Push into a full FIFO while the head is popped.
    apply_reset();
    for (int i = 0; i < 9; i++) step(1'b1, mk_row(i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    check("fullpop_level", level, 8);
    check("fullpop_ovf", overflow, 0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    check("fullpop_count", dut_pops.size(), 9);
    for (int i = 0; i < 9 && i < dut_pops.size(); i++) check("fullpop_row", dut_pops[i], relu(mk_row(i)));
    $display("full+pop: %0d rows drained, overflow=%0b", dut_pops.size(), overflow);

    // Reset in cycle 2 of a row in flight.
    apply_reset();
    step(1'b1, mk_row(3), 1'b1);
    step(1'b0, '0, 1'b1);
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check("midrst_pops", dut_pops.size(), 0);
    check("midrst_level", level, 0);
    check("midrst_ovf", overflow, 0);
    $display("mid reset: %0d stale rows", dut_pops.size());

    // Pointer wrap: 20 rows, ready toggling each cycle.
    apply_reset();
    for (int c = 0; c < 40; c++) step(c % 2 == 0, mk_row(c / 2), c % 2 == 0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    check("wrap_count", dut_pops.size(), 20);
    for (int i = 0; i < 20 && i < dut_pops.size(); i++) check("wrap_row", dut_pops[i], relu(mk_row(i)));
    check("wrap_ovf", overflow, 0);
    $display("wrap: %0d rows popped", dut_pops.size());

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 400; c++) step($urandom_range(0, 99) < 60, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    $display("random: %0d rows popped, overflow=%0b", dut_pops.size(), overflow);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
